de10_lite_ledr_arbiter: RTL
===========================

Name: de10_lite_ledr_arbiter

Overview:
Two-master arbiter that shares the single Avalon-MM slave port of the 10-bit LEDR PIO. Master 0 is the Nios II data master; master 1 is the HW_Timer hardware block, which writes elapsed-time patterns. The block registers one winning command at a time, issues it to the PIO for exactly one cycle, and returns waitrequest and read data to the winner. It sits between the two masters and the PIO's address/chipselect/write_n/writedata/readdata pins.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority with master 0 always winning.
DATA_W, 32, width of writedata and readdata on all ports.
ADDR_W, 2, width of the PIO word address.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
m0_address  in  ADDR_W  master 0 word address
m0_chipselect  in  1  master 0 request
m0_write_n  in  1  master 0 write strobe, active-low
m0_read_n  in  1  master 0 read strobe, active-low
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  high = master 0 must hold its command
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  one-cycle pulse, m0_readdata valid
m1_*  (same 8 signals for master 1)
s_address  out  ADDR_W  to PIO address
s_chipselect  out  1  to PIO chipselect
s_write_n  out  1  to PIO write_n
s_writedata  out  DATA_W  to PIO writedata
s_readdata  in  DATA_W  from PIO readdata (combinational in the PIO)
grant_id  out  1  index of the last granted master (status)

Behaviour:
- Request definition: mX_req = mX_chipselect & (~mX_write_n | ~mX_read_n). If both strobes are low, the access is treated as a write.
- FSM states are IDLE and ISSUE.
- IDLE: if no request is pending, stay in IDLE. Otherwise:
  - Pick the winner. Round-robin: the master that is not grant_id wins a tie. Fixed mode: m0 wins a tie.
  - Latch the winner's address, write_n and writedata into the s_* registers, set s_chipselect=1, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - s_chipselect=1, so the PIO samples the command at the end of this cycle.
  - The winner's waitrequest is low for this cycle only.
  - For a read, capture s_readdata into the winner's readdata register.
  - grant_id <= winner. Next state is always IDLE, and s_chipselect <= 0.
- Read latency: mX_readdatavalid pulses high for 1 cycle, the cycle after ISSUE. mX_readdata holds its value until the next read by that master.
- Write latency: the PIO register updates at the end of the ISSUE cycle. Write accesses never produce readdatavalid.
- Throughput: one transaction per 2 cycles. A losing master keeps waitrequest high and is served in the next IDLE→ISSUE pair, so in round-robin mode neither master waits more than 1 transaction.
- Outputs outside ISSUE: waitrequest=1 for both masters, s_chipselect=0, and s_write_n=1 for read commands.
- Command withdrawn during ISSUE (protocol violation): the latched command is still issued and waitrequest is still pulsed low. No error is flagged.
- Reset asserted (async): go to IDLE immediately. Reset values:
  - s_chipselect=0, s_write_n=1, s_address=0, s_writedata=0
  - both waitrequest=1, both readdatavalid=0, both readdata=0
  - grant_id=1, so m0 wins the first round-robin tie.
  - A transaction in ISSUE when reset asserts is dropped and no readdatavalid is produced.
- Width rule: writedata passes through unmodified; the PIO uses bits [9:0]. readdata is the full DATA_W word from the PIO (upper 22 bits are 0).

Decomposition:
- Package de10_lite_ledr_pkg:
  - state encoding constants ST_IDLE and ST_ISSUE
  - LEDR_W=10, PIO_DATA_ADDR=0
  - a command record type: address, write_n, writedata, master id.
- Sub-module de10_lite_ledr_arb_pick: combinational 2-way winner select from (req0, req1, grant_id, PRIORITY_MODE).
- The top level holds the FSM, the command registers and the readdata registers.

Test Plan:
1. Reset then m0 writes 0x3FF to address 0 → s_chipselect high for 1 cycle 2 cycles after the request, m0_waitrequest low for that cycle, PIO out_port=0x3FF, m1_waitrequest stays 1.
2. m0 writes 0x155 and m1 writes 0x2AA in the same cycle (PRIORITY_MODE=0, after reset) → m0 issued first, then m1. out_port goes 0x155 then 0x2AA. grant_id sequence is 0 then 1.
3. Both masters request continuously for 8 transactions, round-robin → grants strictly alternate 0,1,0,1…, with one transaction every 2 cycles.
4. Same as scenario 3 with PRIORITY_MODE=1 → m0 wins every tie. m1 is served only in cycles where m0_req=0.
5. PIO holds 0x0F0; m1 reads address 0 → m1_readdatavalid pulses 1 cycle after ISSUE with m1_readdata=0x000000F0, and m0_readdatavalid stays 0.
6. Assert reset during the ISSUE cycle of an m0 read → s_chipselect=0 and waitrequest=1 at once, no readdatavalid, grant_id=1. After reset, a new m1 write of 0x001 completes normally.

Source files
------------

// File: rtl/de10_lite_ledr_pkg.sv
// -----------------------------------------------------------------------------
// de10_lite_ledr_pkg
// Shared definitions for the LEDR PIO two-master arbiter:
//   - state_e : arbiter FSM state encoding (ST_IDLE / ST_ISSUE)
//   - LEDR_W, PIO_DATA_ADDR : geometry of the LEDR PIO
//   - cmd_t   : one latched Avalon-MM command (address, write_n, data, master)
// cmd_t field widths match the arbiter's default DATA_W / ADDR_W; an arbiter
// instantiated with other widths needs these constants changed alongside.
// -----------------------------------------------------------------------------
package de10_lite_ledr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    localparam int LEDR_W        = 10;
    localparam int PIO_DATA_ADDR = 0;

    localparam int CMD_ADDR_W = 2;
    localparam int CMD_DATA_W = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] address;
        logic                  write_n;
        logic [CMD_DATA_W-1:0] writedata;
        logic                  master;
    } cmd_t;

endpackage

// File: rtl/de10_lite_ledr_arb_pick.sv
// -----------------------------------------------------------------------------
// de10_lite_ledr_arb_pick
// Combinational 2-way winner select.
//   req0_i, req1_i : request from master 0 / master 1
//   grant_id_i     : master granted in the previous transaction
//   win_o          : index of the winning master (valid when any_o = 1)
//   any_o          : at least one request pending
// PRIORITY_MODE = 0 : round-robin, a tie goes to the master that was not last
//                     granted. PRIORITY_MODE = 1 : master 0 wins every tie.
// -----------------------------------------------------------------------------
module de10_lite_ledr_arb_pick #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_id_i,
    output logic win_o,
    output logic any_o
);

    always_comb begin
        win_o = 1'b0;
        if (req0_i && req1_i) begin
            win_o = (PRIORITY_MODE != 0) ? 1'b0 : ~grant_id_i;
        end else if (req1_i) begin
            win_o = 1'b1;
        end
    end

    assign any_o = req0_i | req1_i;

endmodule

// File: rtl/de10_lite_ledr_arbiter.sv
// -----------------------------------------------------------------------------
// de10_lite_ledr_arbiter
// Shares the single Avalon-MM slave port of the 10-bit LEDR PIO between the
// Nios II data master (m0) and the HW_Timer block (m1). One command is latched
// in IDLE, presented to the PIO for exactly one ISSUE cycle, and the winner
// sees waitrequest low for that cycle. Reads return on mX_readdata with a
// one-cycle mX_readdatavalid pulse in the cycle after ISSUE.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   mX_address/chipselect/write_n/read_n/writedata : master X command
//   mX_waitrequest/readdata/readdatavalid          : master X response
//   s_address/chipselect/write_n/writedata         : to the PIO
//   s_readdata         : from the PIO (combinational on s_address)
//   grant_id           : master served by the most recent transaction
// -----------------------------------------------------------------------------
module de10_lite_ledr_arbiter
    import de10_lite_ledr_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_chipselect,
    input  logic              m0_write_n,
    input  logic              m0_read_n,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_chipselect,
    input  logic              m1_write_n,
    input  logic              m1_read_n,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,

    output logic              grant_id
);

    logic req0;
    logic req1;
    logic any_req;
    logic win;

    state_e            state_q;
    cmd_t              cmd_q;
    logic              cs_q;
    logic [1:0]        wait_q;
    logic [1:0]        rdv_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              grant_q;

    cmd_t              pick_cmd;

    // A request with both strobes low counts as a write: write_n is latched
    // as-is, so the PIO sees write_n = 0.
    assign req0 = m0_chipselect & (~m0_write_n | ~m0_read_n);
    assign req1 = m1_chipselect & (~m1_write_n | ~m1_read_n);

    de10_lite_ledr_arb_pick #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_pick (
        .req0_i     (req0),
        .req1_i     (req1),
        .grant_id_i (grant_q),
        .win_o      (win),
        .any_o      (any_req)
    );

    always_comb begin
        pick_cmd.master = win;
        if (win) begin
            pick_cmd.address   = m1_address;
            pick_cmd.write_n   = m1_write_n;
            pick_cmd.writedata = m1_writedata;
        end else begin
            pick_cmd.address   = m0_address;
            pick_cmd.write_n   = m0_write_n;
            pick_cmd.writedata = m0_writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '{address: '0, write_n: 1'b1, writedata: '0, master: 1'b0};
            cs_q     <= 1'b0;
            wait_q   <= 2'b11;
            rdv_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            // m0 wins the first round-robin tie after reset.
            grant_q  <= 1'b1;
        end else begin
            rdv_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        cmd_q   <= pick_cmd;
                        cs_q    <= 1'b1;
                        // Only the winner's waitrequest drops, and only for
                        // the ISSUE cycle.
                        wait_q  <= win ? 2'b01 : 2'b10;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cs_q          <= 1'b0;
                    wait_q        <= 2'b11;
                    grant_q       <= cmd_q.master;
                    cmd_q.write_n <= 1'b1;
                    if (cmd_q.write_n) begin
                        if (cmd_q.master) begin
                            rdata1_q <= s_readdata;
                            rdv_q[1] <= 1'b1;
                        end else begin
                            rdata0_q <= s_readdata;
                            rdv_q[0] <= 1'b1;
                        end
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_address        = cmd_q.address;
    assign s_chipselect     = cs_q;
    assign s_write_n        = cmd_q.write_n;
    assign s_writedata      = cmd_q.writedata;

    assign m0_waitrequest   = wait_q[0];
    assign m1_waitrequest   = wait_q[1];
    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];
    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;

    assign grant_id         = grant_q;

endmodule
